// File: rtl/data_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// data_ram_arbiter_pkg : owner encodings and shared control constants
// Rev 1.0
// ============================================================================
package data_ram_arbiter_pkg;

    typedef enum logic [0:0] {
        S_M0 = 1'b0,
        S_M1 = 1'b1
    } owner_t;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// data_ram_arbiter : parks the data RAM on the CPU, lends it to the loader
// Rev 1.0
// ============================================================================
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int M0_MAX = 4,
    parameter int M1_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_ce_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [DATA_W-1:0]   m0_data_i,
    output logic [DATA_W-1:0]   m0_data_o,
    output logic                m0_stall_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [DATA_W-1:0]   m1_data_i,
    output logic [DATA_W-1:0]   m1_data_o,
    output logic                m1_ack_o,
    output logic                ram_ce_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W/8-1:0] ram_sel_o,
    output logic [DATA_W-1:0]   ram_data_o,
    input  logic [DATA_W-1:0]   ram_data_i
);

    localparam int C0_W = $clog2(M0_MAX + 1);
    localparam int C1_W = $clog2(M1_MAX + 1);

    owner_t          owner, owner_nxt;
    logic [C0_W-1:0] m0_run, m0_run_nxt;
    logic [C1_W-1:0] m1_run, m1_run_nxt;

    logic in_rst;
    logic m0_req;
    logic m1_req;

    assign in_rst = (rst == RST_ENABLE);
    assign m0_req = (m0_ce_i == CHIP_ENABLE);
    assign m1_req = (m1_req_i == CHIP_ENABLE);

    always_ff @(posedge clk) begin
        if (in_rst) begin
            owner  <= S_M0;
            m0_run <= '0;
            m1_run <= '0;
        end else begin
            owner  <= owner_nxt;
            m0_run <= m0_run_nxt;
            m1_run <= m1_run_nxt;
        end
    end

    always_comb begin
        owner_nxt  = owner;
        m0_run_nxt = m0_run;
        m1_run_nxt = m1_run;
        case (owner)
            S_M0: begin
                if (m1_req && !m0_req) begin
                    owner_nxt  = S_M1;
                    m0_run_nxt = '0;
                end else if (m1_req && m0_req) begin
                    // The CPU access in the hand-over cycle still completes.
                    if (m0_run == C0_W'(M0_MAX - 1)) begin
                        owner_nxt  = S_M1;
                        m0_run_nxt = '0;
                    end else begin
                        m0_run_nxt = m0_run + C0_W'(1);
                    end
                end else begin
                    m0_run_nxt = '0;
                end
            end
            S_M1: begin
                if (!m1_req) begin
                    owner_nxt  = S_M0;
                    m1_run_nxt = '0;
                end else if (m0_req) begin
                    if (m1_run == C1_W'(M1_MAX - 1)) begin
                        owner_nxt  = S_M0;
                        m1_run_nxt = '0;
                    end else begin
                        m1_run_nxt = m1_run + C1_W'(1);
                    end
                end
            end
            default: begin
                owner_nxt  = S_M0;
                m0_run_nxt = '0;
                m1_run_nxt = '0;
            end
        endcase
    end

    // Datapath: every output is forced to zero while reset is held.
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        m0_data_o  = '0;
        m1_data_o  = '0;
        m1_ack_o   = 1'b0;
        m0_stall_o = 1'b0;
        if (!in_rst) begin
            if (owner == S_M0) begin
                ram_ce_o = m0_req;
                if (m0_req) begin
                    ram_we_o   = m0_we_i;
                    ram_addr_o = m0_addr_i;
                    ram_sel_o  = m0_sel_i;
                    ram_data_o = m0_data_i;
                    if (m0_we_i != WRITE_ENABLE) begin
                        m0_data_o = ram_data_i;
                    end
                end
            end else begin
                ram_ce_o   = m1_req;
                m1_ack_o   = m1_req;
                m0_stall_o = m0_req;
                if (m1_req) begin
                    ram_we_o   = m1_we_i;
                    ram_addr_o = m1_addr_i;
                    ram_sel_o  = m1_sel_i;
                    ram_data_o = m1_data_i;
                    if (m1_we_i != WRITE_ENABLE) begin
                        m1_data_o = ram_data_i;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
